seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Time-multiplexed seven-segment driver for an N-digit common-anode display.
- Captures a binary value on a load strobe and converts it to BCD (iterative double-dabble) or hex nibbles.
- Applies leading-zero blanking, overflow indication and a fixed sign digit, then scans the digits at a programmable refresh rate.
- Sits between the calculator result path and the board display pins, and replaces the per-digit combinational decoder.

Parameters:
- NUM_DIGITS, 4, total digits including the top sign digit (min 2).
- VALUE_W, 12, width of the unsigned magnitude input.
- REFRESH_DIV, 100000, clk cycles each digit stays enabled (min 1).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; synchronous and active-low.
- value  input  VALUE_W  unsigned magnitude to display.
- is_neg  input  1  show minus in the sign digit.
- is_dec  input  1  1 = decimal, 0 = hex.
- blank_lz  input  1  1 = blank leading zeros.
- load  input  1  capture strobe; accepted only when busy=0.
- busy  output  1  conversion/commit in progress.
- done  output  1  one-cycle pulse after display registers update.
- ovf  output  1  latched: last committed value did not fit.
- an  output  NUM_DIGITS  digit enables, active-low, one-hot-zero; an[0] = rightmost.
- seg  output  7  active-low segments, bit order {g,f,e,d,c,b,a}.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - an and seg all ones; busy, done, ovf = 0.
  - Scan index 0, divider count 0, FSM IDLE.
  - All digit registers blank.
  - Applies mid-conversion too: the conversion is aborted and nothing is committed.
- Value digits: indices 0..NUM_DIGITS-2.
- Sign digit (index NUM_DIGITS-1):
  - Shows 7'b011_1111 when the committed is_neg=1, else blank 7'b111_1111.
  - Shown even for zero and even when ovf=1.
- FSM states IDLE, CONV, COMMIT; busy=1 in CONV and COMMIT.
- IDLE:
  - load=1 registers value, is_neg, is_dec and blank_lz.
  - Goes to CONV if is_dec=1, else to COMMIT.
  - load while busy=1 is ignored; no queueing.
- CONV:
  - Exactly VALUE_W cycles; one add-3-then-shift step per cycle into a BCD shift register of 4*(NUM_DIGITS-1) bits plus one overflow sticky bit.
  - Sticky bit sets if any bit shifts out of the top BCD digit.
  - Then goes to COMMIT.
- COMMIT (1 cycle):
  - Computes the per-digit 4-bit codes, ovf and blanking.
  - Writes the display registers at the end of the cycle, then returns to IDLE with done=1 for that following cycle.
  - A load in the done cycle is accepted.
- Latency: load accepted at edge T.
  - Hex: display updates at edge T+2, done high T+2..T+3.
  - Decimal: display updates at edge T+VALUE_W+2, done high T+VALUE_W+2..T+VALUE_W+3.
- Hex overflow: any nonzero nibble above digit NUM_DIGITS-2. Decimal overflow: sticky bit set.
- When ovf=1, every value digit shows 'E' = 7'b000_0110.
- Leading-zero blanking (blank_lz=1, ovf=0): value digits above the most significant nonzero digit show blank; digit 0 always shows a glyph, so 0 displays "0".
- Glyphs 0-F use standard active-low patterns.
  - 0 = 100_0000, 1 = 111_1001, 2 = 010_0100, 8 = 000_0000.
  - A = 000_1000, b = 000_0011, C = 100_0110, d = 010_0001, E = 000_0110, F = 000_1110.
  - Decimal never produces codes above 9.
- Scan:
  - The divider counts 0..REFRESH_DIV-1. On the wrap cycle the index advances, wrapping NUM_DIGITS-1 -> 0.
  - an and seg are registered and driven from the same index, so they change together.
  - First enable an = ~1 in the cycle after reset release.
  - Display registers change atomically at the end of COMMIT; the scan is never restarted by load.

Test Plan (NUM_DIGITS=4, VALUE_W=12, REFRESH_DIV=4):
- Reset, then hold rst_n=1 -> an cycles 1110, 1101, 1011, 0111, each for 4 clks, repeating; seg=111_1111 on all digits until the first commit.
- Load 0x2AF, is_dec=0, is_neg=0 -> done at T+2; digit 0 = F (000_1110), digit 1 = A (000_1000), digit 2 = 2 (010_0100), sign blank, ovf=0.
- Load 255, is_dec=1, is_neg=1, blank_lz=1 -> busy 13 cycles, done at T+14; digits show "255", sign 011_1111.
- Load 7, is_dec=1, blank_lz=1 -> digits 2,1 blank, digit 0 = 111_1000. Repeat with value 0 -> digit 0 = 100_0000.
- Load 1234, is_dec=1 -> ovf=1; all value digits show 000_0110.
- Load 1234 again, then assert a second load during CONV -> ignored, one done pulse only. Assert rst_n=0 mid-CONV -> no done, display blank, ovf=0.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment driver: captures a value and converts it to BCD
// (iterative double-dabble) or hex, then scans it with a sign digit onto active-low pins.
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int VALUE_W     = 12,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  is_neg,
    input  logic                  is_dec,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg
);

    localparam int VAL_DIGITS = NUM_DIGITS - 1;
    localparam int BCD_W      = 4 * VAL_DIGITS;
    localparam int EXT_W      = (VALUE_W > BCD_W) ? VALUE_W : BCD_W;
    localparam int CNT_W      = $clog2(VALUE_W + 1);
    localparam int DIV_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;
    localparam logic [6:0] SEG_MINUS = 7'b011_1111;
    localparam logic [6:0] SEG_E     = 7'b000_0110;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t             state_q;
    logic               loadPend_q;
    logic [VALUE_W-1:0] valueSh_q;
    logic               negLat_q;
    logic               decLat_q;
    logic               blankLat_q;
    logic [BCD_W-1:0]   bcd_q;
    logic               sticky_q;
    logic [CNT_W-1:0]   bitCnt_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic [6:0]         dispSeg_q [NUM_DIGITS];
    logic [DIV_W-1:0]   divCnt_q;
    logic [IDX_W-1:0]   scanIdx_q;
    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]         seg_q;

    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   bcdStep_d;
    logic               stickyStep_d;
    logic [EXT_W-1:0]   hexExt;
    logic [BCD_W-1:0]   digitSrc;
    logic [3:0]         code;
    logic               seenNz;
    logic               commitOvf_d;
    logic [6:0]         dispNext_d [NUM_DIGITS];

    function automatic logic [6:0] glyph(input logic [3:0] c);
        case (c)
            4'h0: glyph = 7'b100_0000;
            4'h1: glyph = 7'b111_1001;
            4'h2: glyph = 7'b010_0100;
            4'h3: glyph = 7'b011_0000;
            4'h4: glyph = 7'b001_1001;
            4'h5: glyph = 7'b001_0010;
            4'h6: glyph = 7'b000_0010;
            4'h7: glyph = 7'b111_1000;
            4'h8: glyph = 7'b000_0000;
            4'h9: glyph = 7'b001_0000;
            4'hA: glyph = 7'b000_1000;
            4'hB: glyph = 7'b000_0011;
            4'hC: glyph = 7'b100_0110;
            4'hD: glyph = 7'b010_0001;
            4'hE: glyph = 7'b000_0110;
            default: glyph = 7'b000_1110;
        endcase
    endfunction

    // One double-dabble step; a bit leaving the top BCD digit means the value cannot fit.
    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < VAL_DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        bcdStep_d    = {adj[BCD_W-2:0], valueSh_q[VALUE_W-1]};
        stickyStep_d = sticky_q | adj[BCD_W-1];
    end

    always_comb begin
        hexExt      = EXT_W'(valueSh_q);
        digitSrc    = decLat_q ? bcd_q : hexExt[BCD_W-1:0];
        commitOvf_d = decLat_q ? sticky_q : (|(hexExt >> BCD_W));
        seenNz      = 1'b0;
        code        = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) dispNext_d[i] = SEG_BLANK;
        for (int i = VAL_DIGITS - 1; i >= 0; i--) begin
            code = digitSrc[4*i +: 4];
            if (code != 4'd0) seenNz = 1'b1;
            if (commitOvf_d)                         dispNext_d[i] = SEG_E;
            else if (blankLat_q && !seenNz && i != 0) dispNext_d[i] = SEG_BLANK;
            else                                     dispNext_d[i] = glyph(code);
        end
        dispNext_d[NUM_DIGITS-1] = negLat_q ? SEG_MINUS : SEG_BLANK;
    end

    // Captured inputs are acted on one cycle later, so CONV/COMMIT see stable latches.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            loadPend_q <= 1'b0;
            valueSh_q  <= '0;
            negLat_q   <= 1'b0;
            decLat_q   <= 1'b0;
            blankLat_q <= 1'b0;
            bcd_q      <= '0;
            sticky_q   <= 1'b0;
            bitCnt_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) dispSeg_q[i] <= SEG_BLANK;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (loadPend_q) begin
                        loadPend_q <= 1'b0;
                        bcd_q      <= '0;
                        sticky_q   <= 1'b0;
                        bitCnt_q   <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= decLat_q ? CONV : COMMIT;
                    end else if (load) begin
                        loadPend_q <= 1'b1;
                        valueSh_q  <= value;
                        negLat_q   <= is_neg;
                        decLat_q   <= is_dec;
                        blankLat_q <= blank_lz;
                    end
                end
                CONV: begin
                    bcd_q     <= bcdStep_d;
                    sticky_q  <= stickyStep_d;
                    valueSh_q <= valueSh_q << 1;
                    bitCnt_q  <= bitCnt_q + 1'b1;
                    if (bitCnt_q == CNT_W'(VALUE_W - 1)) state_q <= COMMIT;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) dispSeg_q[i] <= dispNext_d[i];
                    ovf_q   <= commitOvf_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divCnt_q  <= '0;
            scanIdx_q <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
        end else begin
            an_q  <= ~(NUM_DIGITS'(1) << scanIdx_q);
            seg_q <= dispSeg_q[scanIdx_q];
            if (divCnt_q == DIV_W'(REFRESH_DIV - 1)) begin
                divCnt_q  <= '0;
                scanIdx_q <= (scanIdx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scanIdx_q + 1'b1;
            end else begin
                divCnt_q <= divCnt_q + 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed and random loads checked against an arithmetic
// model of the displayed digits, latency and scan sequence.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int VW = 12;
    localparam int RD = 4;
    localparam int VD = ND - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] value = '0;
    logic          isNeg = 1'b0;
    logic          isDec = 1'b0;
    logic          blankLz = 1'b0;
    logic          load = 1'b0;
    logic          busy;
    logic          done;
    logic          ovf;
    logic [ND-1:0] an;
    logic [6:0]    seg;

    int testsRun = 0;
    int testsFailed = 0;
    int relCycles = 0;
    bit monEn = 1'b0;

    logic [6:0] glyphTable [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [6:0] expSeg [ND];
    logic       expOvf;

    always #5 clk = ~clk;

    seg_scan_driver #(.NUM_DIGITS(ND), .VALUE_W(VW), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .is_neg(isNeg), .is_dec(isDec),
        .blank_lz(blankLz), .load(load), .busy(busy), .done(done), .ovf(ovf),
        .an(an), .seg(seg)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Expected display: digit i of the value in the chosen base, blank above the MSD.
    task automatic modelLoad(input int v, input bit dec, input bit neg, input bit blz);
        int base;
        int p;
        base   = dec ? 10 : 16;
        expOvf = (v >= base ** VD);
        for (int i = 0; i < VD; i++) begin
            p = base ** i;
            if (expOvf)                         expSeg[i] = 7'h06;
            else if (blz && i > 0 && v < p)     expSeg[i] = 7'h7F;
            else                                expSeg[i] = glyphTable[(v / p) % base];
        end
        expSeg[ND-1] = neg ? 7'h3F : 7'h7F;
    endtask

    task automatic modelBlank();
        for (int i = 0; i < ND; i++) expSeg[i] = 7'h7F;
        expOvf = 1'b0;
    endtask

    always @(posedge clk) begin
        if (!rst_n) relCycles <= 0;
        else        relCycles <= relCycles + 1;
    end

    always @(negedge clk) begin : anMon
        logic [ND-1:0] expAn;
        if (monEn) begin
            expAn = (relCycles == 0) ? '1 : ~(ND'(1) << (((relCycles - 1) / RD) % ND));
            checkOutput("an_scan", an, expAn);
        end
    end

    task automatic checkDisplay(input string tag);
        for (int c = 0; c < ND * RD + 1; c++) begin
            @(negedge clk);
            for (int i = 0; i < ND; i++) begin
                if (an[i] == 1'b0) checkOutput(tag, seg, expSeg[i]);
            end
        end
    endtask

    // Loads one value, then watches busy/done for a fixed window after the accepting edge.
    task automatic applyStimulus(input string tag, input int v, input bit dec,
                                 input bit neg, input bit blz);
        int busyCnt;
        int doneCnt;
        int doneAt;
        busyCnt = 0;
        doneCnt = 0;
        doneAt  = -1;
        @(posedge clk); #1;
        value = VW'(v); isDec = dec; isNeg = neg; blankLz = blz; load = 1'b1;
        modelLoad(v, dec, neg, blz);
        @(posedge clk); #1;
        load = 1'b0;
        value = VW'($urandom);
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                doneCnt++;
                if (doneAt < 0) doneAt = m;
            end
        end
        checkOutput({tag, "_doneAt"}, doneAt, dec ? VW + 2 : 2);
        checkOutput({tag, "_doneCnt"}, doneCnt, 1);
        checkOutput({tag, "_busyCnt"}, busyCnt, dec ? VW + 1 : 1);
        checkOutput({tag, "_ovf"}, ovf, expOvf);
        checkDisplay({tag, "_seg"});
    endtask

    initial begin
        int doneCnt;
        int doneAt;
        int rv;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_an", an, 4'hF);
        checkOutput("rst_seg", seg, 7'h7F);
        monEn = 1'b1;
        rst_n = 1'b1;
        modelBlank();
        checkDisplay("init_seg");
        checkDisplay("init_seg2");

        applyStimulus("hex2AF", 'h2AF, 0, 0, 0);
        applyStimulus("dec255", 255, 1, 1, 1);
        applyStimulus("dec7", 7, 1, 0, 1);
        applyStimulus("dec0", 0, 1, 0, 1);
        applyStimulus("hex0blz", 0, 0, 1, 1);
        applyStimulus("dec1234", 1234, 1, 0, 0);
        applyStimulus("dec999", 999, 1, 0, 1);
        applyStimulus("dec1000", 1000, 1, 1, 0);

        // Second load during CONV must be dropped.
        @(posedge clk); #1;
        value = VW'(1234); isDec = 1; isNeg = 0; blankLz = 0; load = 1'b1;
        modelLoad(1234, 1, 0, 0);
        @(posedge clk); #1;
        load = 1'b0;
        doneCnt = 0;
        doneAt = -1;
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (done) begin
                doneCnt++;
                if (doneAt < 0) doneAt = m;
            end
            if (m == 4) begin value = VW'(42); isNeg = 1; load = 1'b1; end
            if (m == 5) load = 1'b0;
        end
        checkOutput("ignore_doneCnt", doneCnt, 1);
        checkOutput("ignore_doneAt", doneAt, VW + 2);
        checkOutput("ignore_ovf", ovf, 1);
        checkDisplay("ignore_seg");

        // Load presented during the done cycle is accepted.
        @(posedge clk); #1;
        value = VW'('h5C); isDec = 0; isNeg = 0; blankLz = 1; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        doneAt = -1;
        for (int m = 0; m < 10 && doneAt < 0; m++) begin
            @(negedge clk);
            if (done) doneAt = m;
        end
        checkOutput("b2b_first_doneAt", doneAt, 2);
        value = VW'(86); isDec = 1; isNeg = 1; blankLz = 1; load = 1'b1;
        modelLoad(86, 1, 1, 1);
        @(posedge clk); #1;
        load = 1'b0;
        doneAt = -1;
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (done && doneAt < 0) doneAt = m;
        end
        checkOutput("b2b_second_doneAt", doneAt, VW + 2);
        checkDisplay("b2b_seg");

        // Reset mid-CONV: nothing committed, display blank.
        applyStimulus("pre_rst", 1500, 1, 1, 0);
        @(posedge clk); #1;
        value = VW'(321); isDec = 1; isNeg = 1; blankLz = 0; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        doneCnt = 0;
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (done) doneCnt++;
            if (m == 4) rst_n = 1'b0;
            if (m == 5) rst_n = 1'b1;
        end
        modelBlank();
        checkOutput("midrst_doneCnt", doneCnt, 0);
        checkOutput("midrst_ovf", ovf, 0);
        checkOutput("midrst_busy", busy, 0);
        checkDisplay("midrst_seg");

        for (int k = 0; k < 24; k++) begin
            rv = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 1200))
                                             : int'($urandom_range(0, (1 << VW) - 1));
            applyStimulus("rand", rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)));
        end

        monEn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
